// File: rtl/key_reader.sv
// Pushbutton front end: synchronises and debounces active-low keys, encodes the single
// accepted key and emits press, auto-repeat and release strobes.
module key_reader #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  localparam int unsigned IDX_W          = $clog2(NUM_KEYS)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [IDX_W-1:0]    button,
  output logic                key_down,
  output logic                press_pulse,
  output logic                repeat_pulse,
  output logic                release_pulse,
  output logic                chord
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned NCNT_W  = $clog2(NUM_KEYS + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DLY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST = RPT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {StIdle, StHeld, StWaitAll} state_e;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q, stable_q;
  logic [DB_W-1:0]     db_cnt_q [NUM_KEYS];

  // Synchroniser and per-key debounce counters; released (1) is the reset level.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      for (int i = 0; i < int'(NUM_KEYS); i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          stable_q[i] <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic [NUM_KEYS-1:0] down;
  logic [NCNT_W-1:0]   ndown;
  logic [IDX_W-1:0]    down_idx;

  always_comb begin
    down     = ~stable_q;
    ndown    = '0;
    down_idx = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (down[i]) begin
        ndown    = ndown + 1'b1;
        down_idx = IDX_W'(i);
      end
    end
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] button_q, button_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             chord_q;

  always_comb begin
    state_d   = state_q;
    button_d  = button_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ndown == NCNT_W'(1)) begin
          button_d = down_idx;
          press_d  = 1'b1;
          state_d  = StHeld;
        end else if (ndown >= NCNT_W'(2)) begin
          state_d = StWaitAll;
        end
      end
      StHeld: begin
        // Extra keys are ignored; only the accepted key's release matters.
        if (!down[button_q]) begin
          release_d = 1'b1;
          state_d   = (ndown == '0) ? StIdle : StWaitAll;
        end
      end
      StWaitAll: begin
        if (ndown == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_first_q, rpt_first_d;
  logic             repeat_q, repeat_d;

  // Repeat only while staying in HELD, so a release never coincides with a repeat.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    repeat_d    = 1'b0;
    if (REPEAT_EN == 0 || press_d) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end else if (state_q == StHeld && state_d == StHeld) begin
      if (rpt_cnt_q == (rpt_first_q ? DLY_LAST : RATE_LAST)) begin
        repeat_d    = 1'b1;
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end else begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      button_q    <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      chord_q     <= 1'b0;
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
      repeat_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      button_q    <= button_d;
      press_q     <= press_d;
      release_q   <= release_d;
      chord_q     <= (ndown >= NCNT_W'(2));
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
      repeat_q    <= repeat_d;
    end
  end

  assign button        = button_q;
  assign key_down      = (state_q == StHeld);
  assign press_pulse   = press_q;
  assign repeat_pulse  = repeat_q;
  assign release_pulse = release_q;
  assign chord         = chord_q;

endmodule

// File: tb/tb_key_reader.sv
// Directed bench for key_reader with a short debounce window and fast auto-repeat.
module tb_key_reader;

  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] KEY;
  logic [1:0] button;
  logic       key_down, press_pulse, repeat_pulse, release_pulse, chord;

  int checks = 0;
  int errors = 0;

  key_reader #(
    .NUM_KEYS(4), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_RATE(5)
  ) dut (
    .clock(clock), .resetn(resetn), .KEY(KEY), .button(button), .key_down(key_down),
    .press_pulse(press_pulse), .repeat_pulse(repeat_pulse), .release_pulse(release_pulse),
    .chord(chord)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_button"}, 32'(button), 32'd0);
    check({tag, "_key_down"}, 32'(key_down), 32'd0);
    check({tag, "_press"}, 32'(press_pulse), 32'd0);
    check({tag, "_repeat"}, 32'(repeat_pulse), 32'd0);
    check({tag, "_release"}, 32'(release_pulse), 32'd0);
    check({tag, "_chord"}, 32'(chord), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    KEY    = 4'b1111;
    #2;
    check_idle_outputs("reset");
    tick();
    tick();
    resetn = 1'b1;
    repeat (3) tick();

    // Glitch of 3 cycles must be rejected.
    KEY = 4'b1110;
    repeat (3) tick();
    KEY = 4'b1111;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("glitch_press", 32'(press_pulse), 32'd0);
      check("glitch_key_down", 32'(key_down), 32'd0);
      check("glitch_button", 32'(button), 32'd0);
    end

    // Clean press of key 2, released at cycle 20; repeats at 17 and 22.
    KEY = 4'b1011;
    for (int i = 1; i <= 32; i++) begin
      tick();
      check("clean_press", 32'(press_pulse), 32'(i == 7));
      check("clean_release", 32'(release_pulse), 32'(i == 27));
      check("clean_repeat", 32'(repeat_pulse), 32'(i == 17 || i == 22));
      check("clean_key_down", 32'(key_down), 32'(i >= 7 && i < 27));
      if (i >= 7) check("clean_button", 32'(button), 32'd2);
      if (i == 20) KEY = 4'b1111;
    end

    // Repeat: key 1, repeats at P+10/15/20; the P+25 slot coincides with release.
    KEY = 4'b1101;
    for (int i = 1; i <= 45; i++) begin
      tick();
      check("rpt_press", 32'(press_pulse), 32'(i == 7));
      check("rpt_repeat", 32'(repeat_pulse), 32'(i == 17 || i == 22 || i == 27));
      check("rpt_release", 32'(release_pulse), 32'(i == 32));
      if (i >= 7) check("rpt_button", 32'(button), 32'd1);
      if (i == 25) KEY = 4'b1111;
    end

    // Chord from idle, partial release, then a fresh single press of key 3.
    KEY = 4'b1100;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("chord_press", 32'(press_pulse), 32'd0);
      check("chord_level", 32'(chord), 32'(i >= 7));
    end
    KEY = 4'b1110;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("chord_partial_press", 32'(press_pulse), 32'd0);
      check("chord_partial_level", 32'(chord), 32'(i < 7));
    end
    KEY = 4'b1111;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("chord_allup_pulses", 32'(press_pulse | release_pulse), 32'd0);
    end
    KEY = 4'b0111;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("chord_fresh_press", 32'(press_pulse), 32'(i == 7));
      if (i >= 7) check("chord_fresh_button", 32'(button), 32'd3);
    end
    KEY = 4'b1111;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("chord_fresh_release", 32'(release_pulse), 32'(i == 7));
    end

    // Held key 0 plus extra key 3.
    KEY = 4'b1110;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("extra_press0", 32'(press_pulse), 32'(i == 7));
    end
    check("extra_button0", 32'(button), 32'd0);
    KEY = 4'b0110;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("extra_no_press", 32'(press_pulse), 32'd0);
      check("extra_key_down", 32'(key_down), 32'd1);
      check("extra_chord", 32'(chord), 32'(i >= 7));
    end
    KEY = 4'b0111;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("extra_release", 32'(release_pulse), 32'(i == 7));
      check("extra_wait_press", 32'(press_pulse), 32'd0);
      check("extra_wait_key_down", 32'(key_down), 32'(i < 7));
    end
    KEY = 4'b1111;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("extra_allup_pulses", 32'(press_pulse | release_pulse | repeat_pulse), 32'd0);
    end

    // Reset while key 0 is held.
    KEY = 4'b1110;
    repeat (12) tick();
    check("prereset_key_down", 32'(key_down), 32'd1);
    resetn = 1'b0;
    #1;
    check_idle_outputs("midreset");
    tick();
    tick();
    resetn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("postreset_press", 32'(press_pulse), 32'(i == 7));
      check("postreset_key_down", 32'(key_down), 32'(i >= 7));
      check("postreset_button", 32'(button), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
